// File: rtl/bp_be_stride_detector.sv
// ============================================================================
// Module   : bp_be_stride_detector
// Purpose  : Per-PC constant-stride detector that feeds striding-load requests
//            to the backend prefetch generator over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_be_stride_detector #(
    parameter int vaddr_width_p    = 39,
    parameter int dpath_width_gp   = 64,
    parameter int entries_p        = 8,
    parameter int tag_width_p      = 10,
    parameter int stride_width_p   = 8,
    parameter int loop_range_p     = 8,
    parameter int conf_width_p     = 2,
    parameter int conf_threshold_p = 2,
    parameter int degree_p         = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      flush_i,
    input  logic                      commit_v_i,
    input  logic [vaddr_width_p-1:0]  commit_pc_i,
    input  logic [dpath_width_gp-1:0] commit_eff_addr_i,
    output logic                      v_o,
    input  logic                      ready_and_i,
    output logic [vaddr_width_p-1:0]  pc_o,
    output logic [dpath_width_gp-1:0] eff_addr_o,
    output logic [stride_width_p-1:0] stride_o,
    output logic [loop_range_p-1:0]   loop_counter_o,
    output logic [15:0]               drop_count_o
);

    localparam int                      c_idx_w     = $clog2(entries_p);
    localparam logic [conf_width_p-1:0] c_conf_max  = '1;
    localparam logic [conf_width_p-1:0] c_conf_thr  = conf_threshold_p[conf_width_p-1:0];
    localparam logic [loop_range_p-1:0] c_degree    = degree_p[loop_range_p-1:0];

    logic                      r_valid  [entries_p];
    logic [tag_width_p-1:0]    r_tag    [entries_p];
    logic [dpath_width_gp-1:0] r_last   [entries_p];
    logic [stride_width_p-1:0] r_stride [entries_p];
    logic [conf_width_p-1:0]   r_conf   [entries_p];

    logic                      r_v;
    logic [vaddr_width_p-1:0]  r_pc;
    logic [dpath_width_gp-1:0] r_eff_addr;
    logic [stride_width_p-1:0] r_stride_out;
    logic [loop_range_p-1:0]   r_loop;
    logic [15:0]               r_drop;

    logic [c_idx_w-1:0]                    w_idx;
    logic [vaddr_width_p-3-c_idx_w:0]      w_pc_hi;
    logic [tag_width_p-1:0]                w_tag;
    logic                                  w_hit;
    logic [dpath_width_gp-1:0]             w_delta;
    logic [dpath_width_gp-1:0]             w_stride_ext;
    logic                                  w_same;
    logic                                  w_fits;
    logic [conf_width_p-1:0]               w_conf_inc;
    logic                                  w_trigger;
    logic                                  w_deq;
    logic                                  w_load;
    logic                                  w_drop;
    logic                                  w_unused;

    assign w_idx        = commit_pc_i[2 +: c_idx_w];
    assign w_pc_hi      = commit_pc_i[vaddr_width_p-1:2+c_idx_w];
    assign w_tag        = w_pc_hi[tag_width_p-1:0];
    assign w_unused     = ^{commit_pc_i[1:0], w_pc_hi};

    assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // Delta wraps modulo the datapath width; negative strides become huge and are rejected.
    assign w_delta      = commit_eff_addr_i - r_last[w_idx];
    assign w_stride_ext = {{(dpath_width_gp-stride_width_p){1'b0}}, r_stride[w_idx]};
    assign w_same       = (w_delta == w_stride_ext) && (r_stride[w_idx] != '0);
    assign w_fits       = (w_delta != '0) && (w_delta[dpath_width_gp-1:stride_width_p] == '0);
    assign w_conf_inc   = (r_conf[w_idx] == c_conf_max) ? c_conf_max : r_conf[w_idx] + 1'b1;

    assign w_trigger    = commit_v_i && !flush_i && w_hit && w_same && (w_conf_inc >= c_conf_thr);
    assign w_deq        = r_v && ready_and_i;
    assign w_load       = w_trigger && (!r_v || w_deq);
    assign w_drop       = w_trigger && !w_load;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < entries_p; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_last[i]   <= '0;
                r_stride[i] <= '0;
                r_conf[i]   <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < entries_p; i++) begin
                r_valid[i] <= 1'b0;
                r_conf[i]  <= '0;
            end
        end else if (commit_v_i) begin
            r_last[w_idx] <= commit_eff_addr_i;
            if (!w_hit) begin
                r_valid[w_idx]  <= 1'b1;
                r_tag[w_idx]    <= w_tag;
                r_stride[w_idx] <= '0;
                r_conf[w_idx]   <= '0;
            end else if (w_same) begin
                r_conf[w_idx]   <= w_conf_inc;
            end else if (w_fits) begin
                r_stride[w_idx] <= w_delta[stride_width_p-1:0];
                r_conf[w_idx]   <= '0;
            end else begin
                r_stride[w_idx] <= '0;
                r_conf[w_idx]   <= '0;
            end
        end
    end

    // Single-slot output: payload only changes on a load, so it is stable while stalled.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_v          <= 1'b0;
            r_pc         <= '0;
            r_eff_addr   <= '0;
            r_stride_out <= '0;
            r_loop       <= '0;
            r_drop       <= '0;
        end else if (flush_i) begin
            r_v <= 1'b0;
        end else begin
            if (w_load) begin
                r_v          <= 1'b1;
                r_pc         <= commit_pc_i;
                r_eff_addr   <= commit_eff_addr_i;
                r_stride_out <= r_stride[w_idx];
                r_loop       <= c_degree;
            end else if (w_deq) begin
                r_v <= 1'b0;
            end
            if (w_drop && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    assign v_o            = r_v;
    assign pc_o           = r_pc;
    assign eff_addr_o     = r_eff_addr;
    assign stride_o       = r_stride_out;
    assign loop_counter_o = r_loop;
    assign drop_count_o   = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_bp_be_stride_detector.sv
// ============================================================================
// Module   : tb_bp_be_stride_detector
// Purpose  : Directed self-checking bench for bp_be_stride_detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bp_be_stride_detector;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        commit_v;
    logic [38:0] commit_pc;
    logic [63:0] commit_addr;
    logic        v_o;
    logic        ready;
    logic [38:0] pc_o;
    logic [63:0] eff_addr_o;
    logic [7:0]  stride_o;
    logic [7:0]  loop_o;
    logic [15:0] drop_o;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [38:0] PC_A = 39'h00_8000_0100;
    localparam logic [38:0] PC_B = 39'h00_8000_0104;
    localparam logic [38:0] PC_C = 39'h00_8000_0108;
    localparam logic [38:0] PC_D = 39'h00_8000_0500;

    bp_be_stride_detector dut (
        .clk_i             (clk),
        .reset_n_i         (reset_n),
        .flush_i           (flush),
        .commit_v_i        (commit_v),
        .commit_pc_i       (commit_pc),
        .commit_eff_addr_i (commit_addr),
        .v_o               (v_o),
        .ready_and_i       (ready),
        .pc_o              (pc_o),
        .eff_addr_o        (eff_addr_o),
        .stride_o          (stride_o),
        .loop_counter_o    (loop_o),
        .drop_count_o      (drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [38:0] pc, input logic [63:0] a);
        commit_v    = 1'b1;
        commit_pc   = pc;
        commit_addr = a;
        step();
        commit_v    = 1'b0;
    endtask

    task automatic commit_quiet(input string tag, input logic [38:0] pc, input logic [63:0] a);
        commit(pc, a);
        chk(tag, 64'(v_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; flush = 1'b0; commit_v = 1'b0;
        commit_pc = '0; commit_addr = '0; ready = 1'b1;
        #12;
        chk("rst_v",     64'(v_o),    64'd0);
        chk("rst_pc",    64'(pc_o),   64'd0);
        chk("rst_drop",  64'(drop_o), 64'd0);
        @(negedge clk) reset_n = 1'b1;
        step();

        // Training
        commit_quiet("train1", PC_A, 64'h1000);
        commit_quiet("train2", PC_A, 64'h1008);
        commit_quiet("train3", PC_A, 64'h1010);
        commit(PC_A, 64'h1018);
        chk("train_v",      64'(v_o),        64'd1);
        chk("train_pc",     64'(pc_o),       64'h8000_0100);
        chk("train_addr",   eff_addr_o,      64'h1018);
        chk("train_stride", 64'(stride_o),   64'd8);
        chk("train_loop",   64'(loop_o),     64'd4);
        step();
        chk("train_deq",    64'(v_o),        64'd0);

        // Stride break and retrain
        commit_quiet("brk1", PC_A, 64'h1030);
        commit_quiet("brk2", PC_A, 64'h1048);
        commit(PC_A, 64'h1060);
        chk("brk_v",      64'(v_o),      64'd1);
        chk("brk_addr",   eff_addr_o,    64'h1060);
        chk("brk_stride", 64'(stride_o), 64'h18);
        step();
        chk("brk_deq",    64'(v_o),      64'd0);

        // Ineligible strides: zero, negative, too large
        commit_quiet("inel_a0", PC_B, 64'h1000);
        commit_quiet("inel_z1", PC_B, 64'h1000);
        commit_quiet("inel_z2", PC_B, 64'h1000);
        commit_quiet("inel_z3", PC_B, 64'h1000);
        commit_quiet("inel_n1", PC_B, 64'h0FF8);
        commit_quiet("inel_n2", PC_B, 64'h0FF0);
        commit_quiet("inel_n3", PC_B, 64'h0FE8);
        commit_quiet("inel_l0", PC_B, 64'h1100);
        commit_quiet("inel_l1", PC_B, 64'h1200);
        commit_quiet("inel_l2", PC_B, 64'h1300);
        commit_quiet("inel_l3", PC_B, 64'h1400);

        // Backpressure and drop
        ready = 1'b0;
        commit_quiet("bp_t0", PC_C, 64'h2000);
        commit_quiet("bp_t1", PC_C, 64'h2010);
        commit_quiet("bp_t2", PC_C, 64'h2020);
        commit(PC_C, 64'h2030);
        chk("bp_first_v",    64'(v_o),      64'd1);
        chk("bp_first_addr", eff_addr_o,    64'h2030);
        commit(PC_C, 64'h2040);
        chk("bp_hold_v",      64'(v_o),      64'd1);
        chk("bp_hold_addr",   eff_addr_o,    64'h2030);
        chk("bp_hold_stride", 64'(stride_o), 64'h10);
        chk("bp_drop1",       64'(drop_o),   64'd1);
        ready = 1'b1;
        commit(PC_C, 64'h2050);
        chk("bp_swap_v",    64'(v_o),    64'd1);
        chk("bp_swap_addr", eff_addr_o,  64'h2050);
        chk("bp_swap_drop", 64'(drop_o), 64'd1);
        step();
        chk("bp_deq", 64'(v_o), 64'd0);

        // Alias replacement: same index, different tag
        commit_quiet("alias_new",  PC_D, 64'h5000);
        commit_quiet("alias_old1", PC_A, 64'h1078);
        commit_quiet("alias_old2", PC_A, 64'h1090);
        commit_quiet("alias_old3", PC_A, 64'h10A8);

        // Asynchronous reset with a pending request
        ready = 1'b0;
        commit(PC_C, 64'h2060);
        chk("arst_pre_v", 64'(v_o), 64'd1);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_v",    64'(v_o),      64'd0);
        chk("arst_drop", 64'(drop_o),   64'd0);
        chk("arst_addr", eff_addr_o,    64'd0);
        @(negedge clk) reset_n = 1'b1;
        step();

        // Flush clears the pending request and forces retraining
        commit_quiet("fl_t0", PC_A, 64'h3000);
        commit_quiet("fl_t1", PC_A, 64'h3008);
        commit_quiet("fl_t2", PC_A, 64'h3010);
        commit(PC_A, 64'h3018);
        chk("fl_pre_v", 64'(v_o), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_v", 64'(v_o), 64'd0);
        ready = 1'b1;
        commit_quiet("fl_r1", PC_A, 64'h3020);
        commit_quiet("fl_r2", PC_A, 64'h3028);
        commit_quiet("fl_r3", PC_A, 64'h3030);
        commit(PC_A, 64'h3038);
        chk("fl_retrain_v",    64'(v_o),   64'd1);
        chk("fl_retrain_addr", eff_addr_o, 64'h3038);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
